// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: five periodic tick channels gated by an IDLE/RUN/PAUSED/OVER FSM.
// Optional macro TICK_SCHED_LEVEL_EN scales the blue/green drop periods by LEVEL.
module game_tick_scheduler #(
  parameter int P_PLAYER = 11000004,
  parameter int P_BLUE   = 5000004,
  parameter int P_GREEN  = 4000004,
  parameter int P_SCAN   = 100004,
  parameter int P_SEC    = 110000004
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       HIT,
  input  logic [1:0] LEVEL,
  output logic       TICK_PLAYER,
  output logic       TICK_BLUE,
  output logic       TICK_GREEN,
  output logic       TICK_SCAN,
  output logic       TICK_SEC,
  output logic [1:0] STATE,
  output logic [7:0] SECONDS
);

  localparam int N_CH    = 5;
  localparam int CH_SCAN = 3;
  localparam int CH_SEC  = 4;

  function automatic int period_of(input int ch);
    case (ch)
      0:       return P_PLAYER;
      1:       return P_BLUE;
      2:       return P_GREEN;
      3:       return P_SCAN;
      default: return P_SEC;
    endcase
  endfunction

  function automatic int max_period();
    int m;
    m = P_PLAYER;
    if (P_BLUE  > m) m = P_BLUE;
    if (P_GREEN > m) m = P_GREEN;
    if (P_SCAN  > m) m = P_SCAN;
    if (P_SEC   > m) m = P_SEC;
    return m;
  endfunction

  localparam int P_MAX = max_period();
  localparam int CNT_W = (P_MAX > 1) ? $clog2(P_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              pause_q_reg;
  logic              pause_rise;
  logic              run_en, hold_en, sec_clear;
  logic [N_CH-1:0]   tick_vec;
  logic [7:0]        sec_reg;

  assign pause_rise = PAUSE & ~pause_q_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= S_IDLE;
      pause_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pause_q_reg <= PAUSE;
    end
  end

  // HIT outranks a simultaneous pause edge while running.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (START) state_next = S_RUN;
      S_RUN:    if (HIT) state_next = S_OVER;
                else if (pause_rise) state_next = S_PAUSED;
      S_PAUSED: if (pause_rise) state_next = S_RUN;
      S_OVER:   if (START) state_next = S_RUN;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    run_en    = 1'b0;
    hold_en   = 1'b0;
    sec_clear = 1'b0;
    STATE     = state_reg;
    case (state_reg)
      S_RUN:          run_en    = 1'b1;
      S_PAUSED:       hold_en   = 1'b1;
      S_IDLE, S_OVER: sec_clear = START;
      default: ;
    endcase
  end

`ifndef TICK_SCHED_LEVEL_EN
  logic unused_level;
  assign unused_level = ^LEVEL;
`endif

  // Ticks fire on counter >= Peff-1 so a shrinking period reloads immediately.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam int P_CH     = period_of(gi);
      localparam bit FREE_RUN = (gi == CH_SCAN);
      logic [CNT_W-1:0] cnt_reg;
      logic [31:0]      peff;
      logic             tick;

      if (gi == 1 || gi == 2) begin : g_scaled
`ifdef TICK_SCHED_LEVEL_EN
        logic [31:0] shifted;
        assign shifted = 32'(P_CH) >> LEVEL;
        assign peff    = (shifted < 32'd4) ? 32'd4 : shifted;
`else
        assign peff = 32'(P_CH);
`endif
      end else begin : g_fixed
        assign peff = 32'(P_CH);
      end

      assign tick = (FREE_RUN || run_en) && (32'(cnt_reg) >= (peff - 32'd1));
      assign tick_vec[gi] = tick;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                   cnt_reg <= '0;
        else if (tick)                cnt_reg <= '0;
        else if (FREE_RUN || run_en)  cnt_reg <= cnt_reg + 1'b1;
        else if (!hold_en)            cnt_reg <= '0;
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                    sec_reg <= 8'd0;
    else if (sec_clear)                            sec_reg <= 8'd0;
    else if (tick_vec[CH_SEC] && sec_reg != 8'hFF) sec_reg <= sec_reg + 8'd1;
  end

  assign TICK_PLAYER = tick_vec[0];
  assign TICK_BLUE   = tick_vec[1];
  assign TICK_GREEN  = tick_vec[2];
  assign TICK_SCAN   = tick_vec[CH_SCAN];
  assign TICK_SEC    = tick_vec[CH_SEC];
  assign SECONDS     = sec_reg;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: directed table, hand sequences and
// randomized play against a cycle-level reference model of the game rules.
module tb_game_tick_scheduler;
  localparam int PP = 6, PB = 16, PG = 12, PS = 4, PSEC = 20;

  logic       CLK = 1'b0, RST_N = 1'b0, START = 1'b0, PAUSE = 1'b0, HIT = 1'b0;
  logic [1:0] LEVEL = 2'd0;
  logic       TICK_PLAYER, TICK_BLUE, TICK_GREEN, TICK_SCAN, TICK_SEC;
  logic [1:0] STATE;
  logic [7:0] SECONDS;

  int vectors = 0, miscompares = 0;

  game_tick_scheduler #(.P_PLAYER(PP), .P_BLUE(PB), .P_GREEN(PG), .P_SCAN(PS), .P_SEC(PSEC)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .PAUSE(PAUSE), .HIT(HIT), .LEVEL(LEVEL),
    .TICK_PLAYER(TICK_PLAYER), .TICK_BLUE(TICK_BLUE), .TICK_GREEN(TICK_GREEN),
    .TICK_SCAN(TICK_SCAN), .TICK_SEC(TICK_SEC), .STATE(STATE), .SECONDS(SECONDS)
  );

  always #5 CLK = ~CLK;

  // Reference model: game state, seconds, and per-channel cycles since last tick.
  int m_state, m_sec;
  int m_age [5];
  bit m_pq;
  // Values sampled in the most recent cycle.
  int s_state, s_tp, s_blue, s_sec, game_ticks;

  function automatic void check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_sec = 0; m_pq = 1'b0;
    for (int i = 0; i < 5; i++) m_age[i] = 0;
  endfunction

  function automatic int m_period(int ch, int lvl);
    int p;
    case (ch)
      0: p = PP;
      1: p = PB;
      2: p = PG;
      3: p = PS;
      default: p = PSEC;
    endcase
`ifdef TICK_SCHED_LEVEL_EN
    if (ch == 1 || ch == 2) begin
      p = p / (1 << lvl);
      if (p < 4) p = 4;
    end
`endif
    return p;
  endfunction

  function automatic int model_ticks();
    int t = 0;
    for (int ch = 0; ch < 5; ch++)
      if ((ch == 3 || m_state == 1) && (m_age[ch] + 1 >= m_period(ch, int'(LEVEL))))
        t |= (1 << ch);
    return t;
  endfunction

  function automatic void model_step(int t);
    bit rise = PAUSE && !m_pq;
    for (int ch = 0; ch < 5; ch++) begin
      if ((t & (1 << ch)) != 0)      m_age[ch] = 0;
      else if (ch == 3 || m_state == 1) m_age[ch]++;
      else if (m_state != 2)         m_age[ch] = 0;
    end
    if ((t & 16) != 0 && m_sec < 255) m_sec++;
    case (m_state)
      0: if (START) begin m_state = 1; m_sec = 0; end
      1: if (HIT) m_state = 3; else if (rise) m_state = 2;
      2: if (rise) m_state = 1;
      default: if (START) begin m_state = 1; m_sec = 0; end
    endcase
    m_pq = PAUSE;
  endfunction

  // Called at posedge+1; drives inputs, compares at negedge, advances model at the edge.
  task automatic cycle(input bit s, input bit p, input bit h, input logic [1:0] l);
    int et;
    START = s; PAUSE = p; HIT = h; LEVEL = l;
    @(negedge CLK);
    et = model_ticks();
    check("ticks", int'({TICK_SEC, TICK_SCAN, TICK_GREEN, TICK_BLUE, TICK_PLAYER}), et);
    check("state", int'(STATE), m_state);
    check("seconds", int'(SECONDS), m_sec);
    s_state = int'(STATE); s_tp = int'(TICK_PLAYER); s_blue = int'(TICK_BLUE); s_sec = int'(SECONDS);
    game_ticks += int'(TICK_PLAYER) + int'(TICK_BLUE) + int'(TICK_GREEN) + int'(TICK_SEC);
    model_step(et);
    @(posedge CLK); #1;
  endtask

  typedef struct {
    bit start;
    bit pause;
    bit hit;
    int exp_state;
    bit exp_tp;
  } vec_t;
  vec_t tbl [17];

  initial begin
    int n, sec_frozen;
    for (int i = 0; i < 17; i++) tbl[i] = '{start: 1'b0, pause: 1'b0, hit: 1'b0, exp_state: 1, exp_tp: 1'b0};
    tbl[0].start = 1'b1; tbl[0].exp_state = 0;
    tbl[6].exp_tp = 1'b1; tbl[12].exp_tp = 1'b1;
    tbl[13].pause = 1'b1;
    tbl[14].exp_state = 2;
    tbl[15].pause = 1'b1; tbl[15].exp_state = 2;

    model_reset();
    game_ticks = 0;
    #2;
    check("reset_ticks", int'({TICK_SEC, TICK_SCAN, TICK_GREEN, TICK_BLUE, TICK_PLAYER}), 0);
    check("reset_state", int'(STATE), 0);
    check("reset_seconds", int'(SECONDS), 0);
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();

    // Start, player cadence and a pause/resume round trip.
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].start, tbl[i].pause, tbl[i].hit, 2'd0);
      check("tbl_state", s_state, tbl[i].exp_state);
      check("tbl_player", s_tp, int'(tbl[i].exp_tp));
      $display("vec %0d: start=%0d pause=%0d state=%0d tick_player=%0d",
               i, tbl[i].start, tbl[i].pause, s_state, s_tp);
    end

    // Long pause: no game ticks while PAUSED, scan keeps running.
    cycle(0, 1, 0, 2'd0);
    game_ticks = 0;
    for (int i = 0; i < 50; i++) cycle(0, 1, 0, 2'd0);
    check("paused_game_ticks", game_ticks, 0);
    check("paused_state", s_state, 2);
    cycle(0, 0, 0, 2'd0);
    cycle(0, 1, 0, 2'd0);
    for (int i = 0; i < 25; i++) cycle(0, 0, 0, 2'd0);
    $display("pause/resume: state=%0d seconds=%0d", s_state, s_sec);

    // HIT with a simultaneous PAUSE edge ends the game.
    cycle(0, 1, 1, 2'd0);
    cycle(0, 0, 0, 2'd0);
    check("hit_over_state", s_state, 3);
    sec_frozen = s_sec;
    game_ticks = 0;
    for (int i = 0; i < 30; i++) cycle(0, (i % 3) == 0, (i % 5) == 0, 2'd0);
    check("over_game_ticks", game_ticks, 0);
    check("over_seconds_frozen", s_sec, sec_frozen);
    cycle(1, 0, 0, 2'd0);
    cycle(0, 0, 0, 2'd0);
    check("restart_state", s_state, 1);
    check("restart_seconds", s_sec, 0);
    $display("hit+pause: over then restart, seconds=%0d", s_sec);

    // Level scaling and a period shrink while the blue counter is at 10.
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 2'd2);
    n = 0;
    while (m_age[1] != 10 && n < 40) begin cycle(0, 0, 0, 2'd0); n++; end
    check("blue_reach10", int'(m_age[1] == 10), 1);
    cycle(0, 0, 0, 2'd3);
`ifdef TICK_SCHED_LEVEL_EN
    check("blue_shrink_tick", s_blue, 1);
`else
    check("blue_shrink_tick", s_blue, 0);
`endif
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 2'd3);
    $display("level switch: blue tick at shrink=%0d", s_blue);

    // Seconds saturation.
    for (int i = 0; i < 5300; i++) cycle(0, 0, 0, 2'd0);
    check("seconds_saturate", s_sec, 255);
    $display("saturation: seconds=%0d", s_sec);

    // Asynchronous reset mid-run.
    #2;
    RST_N = 1'b0;
    #1;
    check("async_ticks", int'({TICK_SEC, TICK_SCAN, TICK_GREEN, TICK_BLUE, TICK_PLAYER}), 0);
    check("async_state", int'(STATE), 0);
    check("async_seconds", int'(SECONDS), 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();
    game_ticks = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 2'd0);
    check("post_reset_game_ticks", game_ticks, 0);
    $display("async reset: state=%0d seconds=%0d", s_state, s_sec);

    // Randomized play.
    for (int i = 0; i < 2500; i++) begin
      bit s, p, h;
      logic [1:0] l;
      s = ($urandom % 10) == 0;
      p = (($urandom % 4) == 0) ? !PAUSE : PAUSE;
      h = ($urandom % 30) == 0;
      l = (($urandom % 8) == 0) ? 2'($urandom % 4) : LEVEL;
      cycle(s, p, h, l);
    end
    $display("random: final state=%0d seconds=%0d", s_state, s_sec);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 Parameter P_PLAYER, default 11000004, is the player-move tick period in CLK cycles.
REQ-002 Parameter P_BLUE, default 5000004, is the blue-drop tick period in CLK cycles.
REQ-003 Parameter P_GREEN, default 4000004, is the green-drop tick period in CLK cycles.
REQ-004 Parameter P_SCAN, default 100004, is the display-scan tick period in CLK cycles.
REQ-005 Parameter P_SEC, default 110000004, is the game-timer tick period in CLK cycles; every period parameter SHALL be >= 4.
REQ-006 Port list (name, direction, width, meaning), one port per line:
- CLK  in  1  system clock; the single clock domain.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  start/restart request, level, sampled on the CLK rising edge.
- PAUSE  in  1  pause toggle, level; internal rising-edge detect.
- HIT  in  1  collision indication; ends the game.
- LEVEL  in  2  difficulty level 0..3.
- TICK_PLAYER  out  1  one-cycle pulse.
- TICK_BLUE  out  1  one-cycle pulse.
- TICK_GREEN  out  1  one-cycle pulse.
- TICK_SCAN  out  1  one-cycle pulse.
- TICK_SEC  out  1  one-cycle pulse.
- STATE  out  2  current state: 0 IDLE, 1 RUN, 2 PAUSED, 3 OVER.
- SECONDS  out  8  elapsed game seconds.

Function
REQ-007 Each channel SHALL own a counter that counts 0..Peff-1; TICK SHALL be high for exactly the one cycle in which the counter equals Peff-1, and the counter reloads to 0 on the next edge.
REQ-008 TICK_SCAN counter SHALL run in every state.
REQ-009 PLAYER, BLUE, GREEN and SEC counters SHALL advance only in RUN, hold their value in PAUSED, and be forced to 0 in IDLE and OVER.
REQ-010 No TICK except TICK_SCAN SHALL assert outside RUN.
REQ-011 State transitions, evaluated on each CLK edge:
- IDLE -> RUN on START.
- RUN -> OVER on HIT.
- RUN -> PAUSED on a PAUSE rising edge.
- PAUSED -> RUN on a PAUSE rising edge.
- OVER -> RUN on START.
- All other inputs SHALL leave the state unchanged.
REQ-012 HIT SHALL take priority over a simultaneous PAUSE edge in RUN; HIT SHALL be ignored in IDLE, PAUSED and OVER.
REQ-013 A PAUSE rising edge SHALL be detected as PAUSE=1 with the previous-cycle sample at 0; a held PAUSE SHALL toggle the state only once.
REQ-014 SECONDS SHALL increment on each TICK_SEC cycle and saturate at 255.
REQ-015 SECONDS SHALL be cleared to 0 on the IDLE->RUN and OVER->RUN transitions, and SHALL hold in PAUSED and OVER.
REQ-016 TICK_SEC SHALL be produced in the same cycle as the state reads RUN; the SECONDS update is visible one cycle after TICK_SEC.
REQ-017 All counters SHALL be sized as clog2 of the largest period; no counter may wrap before Peff-1.
REQ-018 If Peff is lowered while a counter is at or above the new Peff-1, that channel SHALL tick in the current cycle and reload; ticks SHALL never be lost or doubled.

Reset
REQ-019 RST_N low SHALL immediately force:
- STATE = IDLE, SECONDS = 0;
- all counters = 0, all TICK outputs = 0;
- the PAUSE edge-detect register = 0.
REQ-020 Release of RST_N SHALL take effect on the next CLK edge.
REQ-021 Reset asserted mid-game SHALL abandon the game, with no residual TICK pulse after release.

Configuration
REQ-022 When the macro TICK_SCHED_LEVEL_EN is defined, the blue and green drop periods SHALL be scaled by LEVEL: Peff = P >> LEVEL (LEVEL 0 gives P, LEVEL 3 gives P/8, truncated, floored at 4).
REQ-023 When TICK_SCHED_LEVEL_EN is not defined, LEVEL SHALL be ignored and Peff = P for every channel.
REQ-024 Player, scan and timer channels SHALL never be scaled.

Verification
All scenarios use P_PLAYER=6, P_BLUE=16, P_GREEN=12, P_SCAN=4, P_SEC=20.
REQ-025 Reset, then START high for 1 cycle -> STATE=1 next cycle; TICK_PLAYER pulses every 6 cycles; first TICK_SEC 20 cycles after entry; SECONDS=1 one cycle later.
REQ-026 In RUN, pulse PAUSE for 1 cycle, hold 50 cycles, pulse again -> STATE=2 with no PLAYER/BLUE/GREEN/SEC ticks; TICK_SCAN continues every 4 cycles; counters resume from held values.
REQ-027 HIT and a PAUSE rising edge in the same RUN cycle -> STATE=3; no further game ticks; SECONDS frozen; then START -> STATE=1 and SECONDS=0.
REQ-028 With macro defined, LEVEL=2 -> TICK_BLUE every 4 cycles and TICK_GREEN every 4 cycles (12>>2=3, floored at 4); LEVEL switched 0->3 while the blue counter is at 10 -> TICK_BLUE pulses in that cycle, then every 4. Without macro -> periods stay 16 and 12.
REQ-029 Force 255 seconds, then another TICK_SEC -> SECONDS stays 255.
REQ-030 RST_N low mid-RUN, asynchronously between edges -> all outputs 0 and STATE=0 before the next edge.
